mem_alu_seq: RTL and testbench

Parametrised memory-backed ALU sequencer: a command names two operand addresses, an operation and a destination address in an internal register file; the block fetches both operands, executes, writes the result back and reports completion. It generalises the fixed 8x32 shift/OR datapath to configurable width and depth, four operations, a ready/valid command handshake, a host load/inspect port and a completion counter. It sits between the control sequencer and the scratch register file.

---
 rtl/mem_alu_seq.sv | 154 +++++++++++++++
 tb/tb_mem_alu_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_alu_seq.sv
// mem_alu_seq: memory-backed ALU sequencer.
// A command names operand A, operand B, an operation and a destination in an
// internal register file. The block reads A, reads B, executes, writes the
// result back, then pulses done. A host port loads and inspects the memory.
module mem_alu_seq #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_a_addr,
    input  logic [ADDR_W-1:0] cmd_b_addr,
    input  logic [ADDR_W-1:0] cmd_c_addr,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WIDTH-1:0]  host_wdata,
    output logic [WIDTH-1:0]  host_rdata,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic [CNT_W-1:0]  op_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SH_W  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WB
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, c_addr_q;
    logic [WIDTH-1:0]  a_reg, b_reg, res_reg;
    logic [WIDTH-1:0]  alu_res;
    logic              accept;

    assign accept     = cmd_valid && cmd_ready;
    assign host_rdata = mem[host_addr];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one fixed pass through the read/execute/write-back steps.
    // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        if (state == IDLE) begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
        end
    end

    // ALU: shifts of WIDTH or more (whole b compared) yield zero; ADD drops the carry.
    always_comb begin
        alu_res = '0;
        unique case (op_q)
            OP_SHL: alu_res = (b_reg >= WIDTH_V) ? '0 : (a_reg << b_reg[SH_W-1:0]);
            OP_OR:  alu_res = a_reg | b_reg;
            OP_ADD: alu_res = a_reg + b_reg;
            OP_XOR: alu_res = a_reg ^ b_reg;
            default: alu_res = '0;
        endcase
    end

    // Command latch, operand fetch, execute and completion reporting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            result   <= '0;
            zero     <= 1'b0;
            done     <= 1'b0;
            op_count <= '0;
        end else begin
            done <= (state == WB);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= cmd_op;
                        a_addr_q <= cmd_a_addr;
                        b_addr_q <= cmd_b_addr;
                        c_addr_q <= cmd_c_addr;
                    end
                end
                RD_A: a_reg   <= mem[a_addr_q];
                RD_B: b_reg   <= mem[b_addr_q];
                EXEC: res_reg <= alu_res;
                WB: begin
                    result   <= res_reg;
                    zero     <= (res_reg == '0);
                    op_count <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Register file: write-back in WB, host writes only while idle.
    // NOTE: the array has no reset; its contents survive rst and are undefined at power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == WB) begin
                mem[c_addr_q] <= res_reg;
            end else if (state == IDLE && host_we) begin
                mem[host_addr] <= host_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_alu_seq.sv
// Testbench for mem_alu_seq: directed commands with hand-computed results.
// Stimulus pushes the expected completion into a queue; a monitor pops and
// compares whenever done is seen.
module tb_mem_alu_seq;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_a_addr = '0;
    logic [ADDR_W-1:0] cmd_b_addr = '0;
    logic [ADDR_W-1:0] cmd_c_addr = '0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [WIDTH-1:0]  host_wdata = '0;
    logic [WIDTH-1:0]  host_rdata;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic [CNT_W-1:0]  op_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_done_cyc = -1;
    logic prev_done = 1'b0;
    exp_t exp_q[$];
    logic [CNT_W-1:0] exp_count = '0;

    mem_alu_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a_addr (cmd_a_addr),
        .cmd_b_addr (cmd_b_addr),
        .cmd_c_addr (cmd_c_addr),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            last_done_cyc <= cyc;
            if (prev_done) check("done_one_cycle", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("zero", 64'(zero), 64'(e.z));
                check("op_count", 64'(op_count), 64'(e.cnt));
            end
        end
        prev_done <= done;
    end

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        @(posedge clk);
        #1;
        host_we    = 1'b0;
    endtask

    task automatic peek(input string name, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp);
        host_addr = a;
        #1;
        check(name, 64'(host_rdata), 64'(exp));
    endtask

    // Offer a command, wait for the accepting edge, return its cycle number.
    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] c, input logic [WIDTH-1:0] exp_res,
                         input bit expect_done, input bit hw, input logic [ADDR_W-1:0] haddr,
                         input logic [WIDTH-1:0] hdata, output int acc_cyc);
        int t;
        cmd_op     = op;
        cmd_a_addr = a;
        cmd_b_addr = b;
        cmd_c_addr = c;
        cmd_valid  = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
        if (hw) begin
            host_we    = 1'b1;
            host_addr  = haddr;
            host_wdata = hdata;
        end
        if (expect_done) begin
            exp_count = exp_count + 1'b1;
            exp_q.push_back('{res: exp_res, z: (exp_res == '0), cnt: exp_count});
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        host_we   = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0, acc1;

        // Reset state.
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // SHL 5 << 4 = 0x50, done four edges after accept.
        host_write(3'd0, 32'h0000_0005);
        host_write(3'd1, 32'h0000_0004);
        issue(2'b00, 3'd0, 3'd1, 3'd2, 32'h0000_0050, 1'b1, 1'b0, 3'd0, '0, acc0);
        check("ready_low_busy", 64'(cmd_ready), 64'd0);
        check("busy_high", 64'(busy), 64'd1);
        wait_idle();
        check("shl_latency", 64'(last_done_cyc - acc0), 64'd4);
        peek("shl_mem2", 3'd2, 32'h0000_0050);

        // ADD with carry out wraps to zero, aliasing A and C.
        host_write(3'd3, 32'hFFFF_FFFF);
        host_write(3'd4, 32'h0000_0001);
        issue(2'b10, 3'd3, 3'd4, 3'd3, 32'h0000_0000, 1'b1, 1'b0, 3'd0, '0, acc0);
        wait_idle();
        peek("add_mem3", 3'd3, 32'h0000_0000);

        // SHL by exactly WIDTH gives zero.
        host_write(3'd4, 32'd32);
        issue(2'b00, 3'd0, 3'd4, 3'd2, 32'h0000_0000, 1'b1, 1'b0, 3'd0, '0, acc0);
        wait_idle();
        peek("shl32_mem2", 3'd2, 32'h0000_0000);

        // OR then XOR back-to-back with cmd_valid held.
        host_write(3'd0, 32'hF0F0_0000);
        host_write(3'd1, 32'h0F0F_FFFF);
        issue(2'b01, 3'd0, 3'd1, 3'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd0, '0, acc0);
        issue(2'b11, 3'd0, 3'd1, 3'd6, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd0, '0, acc1);
        check("b2b_spacing", 64'(acc1 - acc0), 64'd5);
        wait_idle();
        peek("or_mem5", 3'd5, 32'hFFFF_FFFF);
        peek("xor_mem6", 3'd6, 32'hFFFF_FFFF);

        // Fully aliased XOR; host write during RD_B must be ignored.
        host_write(3'd7, 32'h1234_5678);
        issue(2'b11, 3'd7, 3'd7, 3'd7, 32'h0000_0000, 1'b1, 1'b0, 3'd0, '0, acc0);
        @(posedge clk);
        #1;
        host_we    = 1'b1;
        host_addr  = 3'd7;
        host_wdata = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        host_we = 1'b0;
        peek("busy_write_ignored", 3'd7, 32'h1234_5678);
        wait_idle();
        peek("alias_mem7", 3'd7, 32'h0000_0000);

        // Host write in the accept cycle feeds that command: 9 + 9.
        issue(2'b10, 3'd0, 3'd0, 3'd1, 32'h0000_0012, 1'b1, 1'b1, 3'd0, 32'h0000_0009, acc0);
        wait_idle();
        peek("accept_write_mem1", 3'd1, 32'h0000_0012);

        // Reset during EXEC abandons the command.
        host_write(3'd0, 32'h0000_0003);
        host_write(3'd1, 32'h0000_0004);
        host_write(3'd2, 32'h0000_DEAD);
        issue(2'b10, 3'd0, 3'd1, 3'd2, '0, 1'b0, 1'b0, 3'd0, '0, acc0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd1);
        check("abort_op_count", 64'(op_count), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        exp_count = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        peek("abort_mem2", 3'd2, 32'h0000_DEAD);

        // Normal command after reset: 3 + 4.
        issue(2'b10, 3'd0, 3'd1, 3'd2, 32'h0000_0007, 1'b1, 1'b0, 3'd0, '0, acc0);
        wait_idle();
        peek("post_rst_mem2", 3'd2, 32'h0000_0007);

        check("all_done_seen", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
